// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and default geometry for the ALU operation sequencer.
// State encoding is shared so the bench and any future debug taps decode it identically.
package alu_op_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_A    = 3'd1,
        ST_WR_B    = 3'd2,
        ST_FIRE    = 3'd3,
        ST_WAIT    = 3'd4,
        ST_PUSH_LO = 3'd5,
        ST_PUSH_HI = 3'd6
    } seq_state_e;

    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned ADDR_W_DEF      = 4;
    localparam int unsigned FUN_W_DEF       = 4;
    localparam int unsigned TIMEOUT_CYC_DEF = 16;
    localparam int unsigned OPA_ADDR_DEF    = 0;
    localparam int unsigned OPB_ADDR_DEF    = 1;

endpackage

// File: rtl/alu_op_sequencer_seq_timeout_cnt.sv
// Saturating WAIT-state cycle counter; tc_o is high while the count sits at TIMEOUT_CYC-1.
// Clear has priority over enable so the count restarts cleanly on every WAIT entry.
module seq_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned     CW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/alu_op_sequencer.sv
// One ALU operation per request: optional operand writes, fire, wait (with timeout), push 2 result bytes LSB first.
// Every output is decoded from registered state except w_inc_o, which follows f_full_i combinationally.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned FUN_W       = FUN_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned OPA_ADDR    = OPA_ADDR_DEF,
    parameter int unsigned OPB_ADDR    = OPB_ADDR_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_with_ops_i,
    input  logic [DATA_W-1:0]     req_op_a_i,
    input  logic [DATA_W-1:0]     req_op_b_i,
    input  logic [FUN_W-1:0]      req_fun_i,
    output logic                  wr_en_o,
    output logic [ADDR_W-1:0]     address_o,
    output logic [DATA_W-1:0]     wr_d_o,
    output logic                  clk_g_en_o,
    output logic                  alu_en_o,
    output logic [FUN_W-1:0]      alu_fun_o,
    input  logic [2*DATA_W-1:0]   alu_out_i,
    input  logic                  alu_out_valid_i,
    output logic                  w_inc_o,
    output logic [DATA_W-1:0]     wr_data_o,
    input  logic                  f_full_i,
    output logic                  busy_o,
    output logic                  timeout_err_o
);

    localparam logic [ADDR_W-1:0] A_ADDR = ADDR_W'(OPA_ADDR);
    localparam logic [ADDR_W-1:0] B_ADDR = ADDR_W'(OPB_ADDR);

    seq_state_e            state_q, state_d;
    logic [DATA_W-1:0]     op_a_q, op_a_d;
    logic [DATA_W-1:0]     op_b_q, op_b_d;
    logic [FUN_W-1:0]      fun_q, fun_d;
    logic [2*DATA_W-1:0]   res_q, res_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  cnt_clr, cnt_en, cnt_tc;
    logic                  push_ok;

    // FIRE always precedes WAIT, so clearing there gives a zero count on WAIT entry.
    assign cnt_clr = (state_q == ST_FIRE);
    assign cnt_en  = (state_q == ST_WAIT);

    seq_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    assign push_ok = ((state_q == ST_PUSH_LO) || (state_q == ST_PUSH_HI)) && !f_full_i;

    always_comb begin
        state_d       = state_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        fun_d         = fun_q;
        res_d         = res_q;
        timeout_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    op_a_d  = req_op_a_i;
                    op_b_d  = req_op_b_i;
                    fun_d   = req_fun_i;
                    state_d = req_with_ops_i ? ST_WR_A : ST_FIRE;
                end
            end
            ST_WR_A: state_d = ST_WR_B;
            ST_WR_B: state_d = ST_FIRE;
            ST_FIRE: state_d = ST_WAIT;
            ST_WAIT: begin
                // A result arriving on the expiry cycle still completes the operation.
                if (alu_out_valid_i) begin
                    res_d   = alu_out_i;
                    state_d = ST_PUSH_LO;
                end else if (cnt_tc) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_PUSH_LO: if (push_ok) state_d = ST_PUSH_HI;
            ST_PUSH_HI: if (push_ok) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            op_a_q        <= '0;
            op_b_q        <= '0;
            fun_q         <= '0;
            res_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            fun_q         <= fun_d;
            res_q         <= res_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        wr_en_o   = 1'b0;
        address_o = '0;
        wr_d_o    = '0;
        wr_data_o = res_q[DATA_W-1:0];
        case (state_q)
            ST_WR_A: begin
                wr_en_o   = 1'b1;
                address_o = A_ADDR;
                wr_d_o    = op_a_q;
            end
            ST_WR_B: begin
                wr_en_o   = 1'b1;
                address_o = B_ADDR;
                wr_d_o    = op_b_q;
            end
            ST_PUSH_HI: wr_data_o = res_q[2*DATA_W-1:DATA_W];
            default: ;
        endcase
    end

    assign req_ready_o   = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign clk_g_en_o    = (state_q == ST_FIRE) || (state_q == ST_WAIT);
    assign alu_en_o      = (state_q == ST_FIRE);
    assign alu_fun_o     = fun_q;
    assign w_inc_o       = push_ok;
    assign timeout_err_o = timeout_err_q;

endmodule
